// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO for the edge-detection pixel path.
// Register-array storage (never reset), registered occupancy count, flags decoded
// from the registered count, and 1-cycle overflow/underflow pulses.
// Optional macro FIFO_FWFT_EN selects first-word fall-through output; when it is
// undefined, dout/valid are registered and update only on an accepted read.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        din,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        dout,
    output logic                     valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   data_count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0]  AE_C    = CNT_W'(AE_THRESH);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_acc, rd_acc;

    // Flags come only from the registered count, so wr_en/rd_en never reach them combinationally.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign data_count   = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Accept decisions, pointer/count next state and the rejected-request pulses.
    always_comb begin
        wr_acc      = wr_en & ~full;
        rd_acc      = rd_en & ~empty;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = wr_en & full;
        underflow_d = rd_en & empty;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state registers; reset discards contents by clearing pointers and count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array write; deliberately has no reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= din;
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented directly; rd_en only acknowledges it.
    assign dout  = mem_q[rd_ptr_q];
    assign valid = ~empty;
`else
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;

    // Registered read port: load the head word on an accepted read, otherwise hold.
    always_comb begin
        dout_d  = dout_q;
        valid_d = rd_acc;
        if (rd_acc) dout_d = mem_q[rd_ptr_q];
    end

    // Output data/valid registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign dout  = dout_q;
    assign valid = valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed + random scoreboard bench for sync_fifo_param
// (DATA_W=8, DEPTH=16, AF_THRESH=14, AE_THRESH=2). Covers both output modes
// depending on FIFO_FWFT_EN.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] dout;
    logic       valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] data_count;
    logic       overflow;
    logic       underflow;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q [$];
    int         mcount;
    logic [7:0] m_dout;

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout), .valid(valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .data_count(data_count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_count", data_count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_almost_empty", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_valid", valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);
`ifndef FIFO_FWFT_EN
        chk("rst_dout", dout, 0);
`endif
    endtask

    // One clock cycle of stimulus, with the reference model advanced and all outputs checked.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        logic       was_full, was_empty, wacc, racc;
        logic [7:0] popped;
        wr_en = w;
        rd_en = r;
        din   = d;
        was_full  = (mcount == 16);
        was_empty = (mcount == 0);
        wacc = w && !was_full;
        racc = r && !was_empty;
`ifdef FIFO_FWFT_EN
        if (racc) chk("fwft_head", dout, exp_q[0]);
`endif
        @(posedge clk);
        #1;
        popped = 8'h00;
        if (racc) popped = exp_q.pop_front();
        if (wacc) exp_q.push_back(d);
        mcount = mcount + int'(wacc) - int'(racc);
        if (racc) m_dout = popped;
        chk("count", data_count, mcount);
        chk("full", full, mcount == 16);
        chk("empty", empty, mcount == 0);
        chk("almost_full", almost_full, mcount >= 14);
        chk("almost_empty", almost_empty, mcount <= 2);
        chk("overflow", overflow, w && was_full);
        chk("underflow", underflow, r && was_empty);
`ifdef FIFO_FWFT_EN
        chk("valid", valid, mcount != 0);
`else
        chk("valid", valid, racc);
        chk("dout", dout, m_dout);
`endif
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        logic       rw, rr;
        logic [7:0] rd;
        int         guard;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
        mcount = 0; m_dout = 8'h00;

        // Power-on reset state.
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid-burst with five words stored.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h30 + 8'(i));
        wr_en = 1'b1; din = 8'h55;
        #3;
        rst = 1'b1;
        #1;
        chk_reset();
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        mcount = 0; m_dout = 8'h00;
        cyc(1'b0, 1'b0, 8'h00);

        // Fill to full, then a rejected write.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i));
        cyc(1'b1, 1'b0, 8'hFF);
        cyc(1'b0, 1'b0, 8'h00);

        // Drain in order, then a rejected read.
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);

        // Simultaneous read/write at full, empty and mid-level.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'h40 + 8'(i));
        cyc(1'b1, 1'b1, 8'h99);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b1, 8'h77);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 8'h60 + 8'(i));
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'h70 + 8'(i));
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 8'h00);

        // Random interleaving with pointer wrap.
        for (int i = 0; i < 40; i++) begin
            rw = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            rd = 8'($urandom_range(0, 255));
            cyc(rw, rr, rd);
        end
        guard = 0;
        while (mcount > 0 && guard < 40) begin
            cyc(1'b0, 1'b1, 8'h00);
            guard++;
        end
        chk("drain_done", mcount, 0);

`ifdef FIFO_FWFT_EN
        // Fall-through: head visible without a read, acknowledge empties the FIFO.
        cyc(1'b1, 1'b0, 8'hA5);
        chk("fwft_a5_dout", dout, 8'hA5);
        chk("fwft_a5_empty", empty, 0);
        cyc(1'b0, 1'b1, 8'h00);
        chk("fwft_ack_empty", empty, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
